// File: rtl/hd44780_if.sv
// hd44780_if: request handshake between display logic and the LCD sequencer.
interface hd44780_if;
    logic       req;
    logic       rs_in;
    logic [7:0] data_in;
    logic       ready;
    logic       init_done;
    modport master(output req, rs_in, data_in, input ready, init_done);
    modport slave(input req, rs_in, data_in, output ready, init_done);
endinterface

// File: rtl/hd44780_ctrl.sv
// hd44780_ctrl: write-only HD44780 8-bit bus sequencer with built-in power-on init.
module hd44780_ctrl #(
    parameter int T_POWERUP = 480000,
    parameter int T_INIT    = 49200,
    parameter int T_EN      = 6,
    parameter int T_CMD     = 600,
    parameter int T_CLR     = 19200,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    hd44780_if.slave   bus,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);
    localparam logic [2:0] POWERUP = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] E_HIGH  = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] IDLE    = 3'd4;

    logic [2:0]       state, nstate, idx, nidx;
    logic [CNT_W-1:0] cnt, tgt, wait_last, nwait;
    logic             in_init, ready, init_done, last, load, accept, nrs;
    logic [7:0]       nbyte;

    function automatic logic [7:0] rom_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h38;
            3'd4:             return 8'h08;
            3'd5:             return 8'h01;
            3'd6:             return 8'h06;
            default:          return 8'h0C;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] rom_wait(input logic [2:0] i);
        return i < 3'd2 ? CNT_W'(T_INIT) : i == 3'd5 ? CNT_W'(T_CLR) : CNT_W'(T_CMD);
    endfunction

    always_comb begin
        accept = state == IDLE && bus.req;
        // POWERUP counts from the first edge out of reset, hence no -1 here
        tgt    = state == POWERUP ? CNT_W'(T_POWERUP) :
                 state == E_HIGH  ? CNT_W'(T_EN - 1) :
                 state == WAIT    ? wait_last : '0;
        last   = cnt == tgt;
        case (state)
            POWERUP: nstate = last ? SETUP : POWERUP;
            SETUP:   nstate = E_HIGH;
            E_HIGH:  nstate = last ? WAIT : E_HIGH;
            WAIT:    nstate = !last ? WAIT : (in_init && idx != 3'd7) ? SETUP : IDLE;
            IDLE:    nstate = accept ? SETUP : IDLE;
            default: nstate = POWERUP;
        endcase
        load  = nstate == SETUP;
        nidx  = state == POWERUP ? 3'd0 : idx + 3'd1;
        nrs   = !in_init && bus.rs_in;
        nbyte = in_init ? rom_byte(nidx) : bus.data_in;
        nwait = in_init ? rom_wait(nidx) :
                (!bus.rs_in && bus.data_in[7:2] == 6'd0 && bus.data_in != 8'd0) ? CNT_W'(T_CLR) : CNT_W'(T_CMD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= POWERUP;
            cnt       <= '0;
            idx       <= '0;
            in_init   <= 1'b1;
            wait_last <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state <= nstate;
            cnt   <= nstate != state ? '0 : cnt + 1'b1;
            lcd_e <= nstate == E_HIGH;
            ready <= nstate == IDLE;
            if (load) begin
                idx       <= nidx;
                lcd_rs    <= nrs;
                lcd_data  <= nbyte;
                wait_last <= nwait - CNT_W'(1);
            end
            if (in_init && state == WAIT && nstate == IDLE) begin
                init_done <= 1'b1;
                in_init   <= 1'b0;
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.init_done = init_done;
    assign lcd_rw        = 1'b0;
endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb_hd44780_ctrl: vector table, random writes and init/reset sequences vs. a timeline model.
module tb_hd44780_ctrl;
    localparam int T_POWERUP = 100;
    localparam int T_INIT    = 50;
    localparam int T_EN      = 3;
    localparam int T_CMD     = 10;
    localparam int T_CLR     = 40;

    typedef struct {
        int         start;
        logic       rs;
        logic [7:0] data;
        int         width;
        bit         stable;
    } pulse_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    pulse_t     pq[$];
    pulse_t     cur;
    logic       prev_e = 1'b0;

    hd44780_if bus();

    hd44780_ctrl #(
        .T_POWERUP(T_POWERUP), .T_INIT(T_INIT), .T_EN(T_EN),
        .T_CMD(T_CMD), .T_CLR(T_CLR), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every E pulse: start cycle, width, and whether RS/DB held still while E was high
    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            cur.start  = cyc;
            cur.rs     = lcd_rs;
            cur.data   = lcd_data;
            cur.width  = 1;
            cur.stable = 1'b1;
        end else if (lcd_e) begin
            cur.width = cur.width + 1;
            if (lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable = 1'b0;
        end
        if (!lcd_e && prev_e) pq.push_back(cur);
        prev_e = lcd_e;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int n = 0;
        while (bus.ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus.ready === 1'b1;
    endtask

    function automatic int write_wait(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLR : T_CMD;
    endfunction

    task automatic check_pulse(input string name, input int base, input logic rs, input logic [7:0] d);
        pulse_t p;
        chk({name, "_pulse_seen"}, pq.size() > 0, 1);
        if (pq.size() > 0) begin
            p = pq.pop_front();
            chk({name, "_setup"}, p.start - base, 1);
            chk({name, "_rs"}, p.rs, rs);
            chk({name, "_data"}, p.data, d);
            chk({name, "_width"}, p.width, T_EN);
            chk({name, "_stable"}, p.stable, 1);
        end
    endtask

    task automatic check_init(input int t0);
        logic [7:0] rom_ref[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        int         wait_ref[8] = '{T_INIT, T_INIT, T_CMD, T_CMD, T_CMD, T_CLR, T_CMD, T_CMD};
        int         t = T_POWERUP;
        bit         ok;
        wait_ready(2000, ok);
        chk("init_timeout", ok, 1);
        chk("init_npulse", pq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_pulse("init", t0 + t, 1'b0, rom_ref[k]);
            t += 1 + T_EN + wait_ref[k];
        end
        chk("init_ready_time", cyc - t0, t);
        chk("init_done", bus.init_done, 1);
    endtask

    task automatic do_write(input string name, input logic rs, input logic [7:0] d, input int exp_lat);
        int a;
        bit ok;
        bus.req = 1'b1;
        bus.rs_in = rs;
        bus.data_in = d;
        a = cyc + 1;
        @(negedge clk);
        bus.req = 1'b0;
        bus.rs_in = ~rs;
        bus.data_in = 8'($urandom);
        chk({name, "_busy"}, bus.ready, 0);
        wait_ready(200, ok);
        chk({name, "_timeout"}, ok, 1);
        chk({name, "_latency"}, cyc - a, exp_lat);
        chk({name, "_hold_data"}, lcd_data, d);
        chk({name, "_hold_rs"}, lcd_rs, rs);
        check_pulse(name, a, rs, d);
    endtask

    vec_t   vecs[8];
    logic   r;
    logic [7:0] d;
    int     t0, n;
    bit     ok;
    logic [7:0] exp_q[$];
    pulse_t p, prev_p;

    initial begin
        vecs = '{'{1'b1, 8'h41, 14}, '{1'b0, 8'h01, 44}, '{1'b0, 8'h80, 14}, '{1'b0, 8'h02, 44},
                 '{1'b0, 8'h03, 44}, '{1'b0, 8'h00, 14}, '{1'b1, 8'h01, 14}, '{1'b0, 8'h04, 14}};
        bus.req = 1'b0;
        bus.rs_in = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 8'h00);
        rst = 1'b1;
        t0 = cyc + 1;
        check_init(t0);

        for (int i = 0; i < 8; i++) do_write($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].lat);

        for (int i = 0; i < 16; i++) begin
            r = 1'($urandom);
            d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            do_write($sformatf("rnd%0d", i), r, d, 1 + T_EN + write_wait(r, d));
        end
        chk("rw_low", lcd_rw, 0);

        // req held high with data changing every cycle: one accept per ready window
        n = 50;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (bus.ready === 1'b1) exp_q.push_back(d);
            bus.req = 1'b1;
            bus.rs_in = 1'b1;
            bus.data_in = d;
            @(negedge clk);
        end
        bus.req = 1'b0;
        wait_ready(200, ok);
        chk("b2b_timeout", ok, 1);
        chk("b2b_accepts", exp_q.size(), (n + 1 + T_EN + T_CMD) / (2 + T_EN + T_CMD));
        chk("b2b_npulse", pq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && pq.size() > 0; i++) begin
            p = pq.pop_front();
            chk("b2b_data", p.data, exp_q[i]);
            chk("b2b_rs", p.rs, 1);
            chk("b2b_stable", p.stable, 1);
            if (i > 0) chk("b2b_spacing", p.start - prev_p.start, 2 + T_EN + T_CMD);
            prev_p = p;
        end
        pq.delete();

        // reset while E is high in a user write
        bus.req = 1'b1;
        bus.rs_in = 1'b1;
        bus.data_in = 8'h55;
        @(negedge clk);
        bus.req = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_e_seen", lcd_e, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_e", lcd_e, 0);
        chk("midrst_ready", bus.ready, 0);
        chk("midrst_init_done", bus.init_done, 0);
        @(posedge clk);
        pq.delete();
        @(negedge clk);
        rst = 1'b1;
        t0 = cyc + 1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            bus.req = 1'b1;
            bus.rs_in = 1'($urandom);
            bus.data_in = 8'($urandom);
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
        check_init(t0);
        do_write("post_reinit", 1'b0, 8'h80, 1 + T_EN + T_CMD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hd44780_ctrl.md
Name: hd44780_ctrl

Overview:
- Sequencer for an HD44780 character LCD on the 8-bit parallel bus, write-only (RW tied low).
- After reset it runs the power-on initialisation sequence by itself.
- It then accepts single command/data bytes from a requester over a ready/req handshake and produces correctly timed RS/E/DB strobes.
- It sits between the top-level display logic and the LCD pins and replaces ad-hoc divided-clock strobing. All timing uses cycle counters on clk; no derived clocks.

Parameters:
- T_POWERUP, 480000, clk cycles of wait after reset before the first init write (40 ms at 12 MHz).
- T_INIT, 49200, wait after each of the first two 0x30 init writes (4.1 ms).
- T_EN, 6, E-high pulse width in cycles (>=1).
- T_CMD, 600, post-write wait for normal commands and data (50 us, >=1).
- T_CLR, 19200, post-write wait for clear (0x01) and home (0x02/0x03) (1.6 ms).
- CNT_W, 20, width of the shared timing counter; must hold the largest T_* value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- req  in  1  write request; sampled only while ready=1
- rs_in  in  1  0=command, 1=data; latched on accept
- data_in  in  8  byte to write; latched on accept
- ready  out  1  controller idle and init complete; can accept a write
- init_done  out  1  set after the init sequence completes; stays high until reset
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW, constant 0
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD DB7..DB0

Behaviour:
- Reset (rst=0 at posedge): state=POWERUP, counter=0. Outputs: ready=0, init_done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
- Reset mid-operation behaves the same: E is low after that edge and the init sequence restarts from POWERUP. Any in-flight write is dropped.
- All outputs are registered.
- States: POWERUP, SETUP, E_HIGH, WAIT, IDLE. Flag in_init selects whether the byte comes from the init ROM or from the latched request.
- POWERUP: runs for T_POWERUP cycles, then goes to SETUP with ROM index 0.
- Init ROM, all bytes with RS=0, as byte/wait pairs:
  - 0x30/T_INIT, 0x30/T_INIT, 0x30/T_CMD, 0x38/T_CMD
  - 0x08/T_CMD, 0x01/T_CLR, 0x06/T_CMD, 0x0C/T_CMD
- SETUP: 1 cycle. lcd_rs and lcd_data are driven, lcd_e=0 (address setup).
- E_HIGH: lcd_e=1 for exactly T_EN cycles. RS/data are held stable.
- WAIT: lcd_e=0 and RS/data are held for the selected wait. Then:
  - in init, if the ROM index is below 7: advance the index and go to SETUP;
  - in init, after index 7: set init_done=1, leave in_init, go to IDLE;
  - otherwise: go to IDLE.
- IDLE: ready=1. An accept occurs on a posedge with ready=1 and req=1. On accept:
  - latch rs_in and data_in;
  - ready=0 from the next cycle;
  - go to SETUP.
- User write wait selection:
  - T_CLR if rs_in=0 and data_in[7:2]=0 and data_in is nonzero (0x01, 0x02, 0x03);
  - else T_CMD (this includes 0x00 and all data bytes).
- Latency: ready is high again exactly 1+T_EN+wait cycles after the accept edge. Back-to-back requests are therefore spaced by that period plus 1 IDLE cycle.
- req while ready=0 is ignored (no queueing, no error). rs_in/data_in changes after accept have no effect.
- ready is never high before init_done. The first ready=1 occurs T_POWERUP + sum over the ROM of (1+T_EN+wait) cycles after the first posedge with rst=1.
- Counter rules: counter resets to 0 on every state entry and compares against (T-1). There is no wrap-around within CNT_W by construction.

Test Plan (params T_POWERUP=100, T_INIT=50, T_EN=3, T_CMD=10, T_CLR=40):
- Release reset, req=0 -> lcd_e stays 0 for 101 cycles. Then 8 E pulses of 3 cycles each with lcd_data 30,30,30,38,08,01,06,0C and lcd_rs=0. init_done and ready rise 322 cycles after reset release.
- After init, req=1 with rs_in=1, data_in=0x41 -> lcd_rs=1, lcd_data=0x41 for 1 setup cycle. lcd_e high for 3 cycles. ready returns 14 cycles after the accept.
- Command 0x01 with rs_in=0 -> ready returns 44 cycles after accept. Repeat with 0x80 -> 14 cycles.
- Hold req=1 continuously with changing data_in -> exactly one accept per ready window. lcd_data stays constant during E_HIGH and WAIT.
- Assert rst=0 while lcd_e=1 in a user write -> lcd_e=0 and ready=0 at the next edge. The init sequence repeats in full from POWERUP.
- req=1 during init (ready=0) -> no extra E pulse. The init byte sequence is unchanged.
